// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access controller.
package mem_pkg;

  // Access size encodings carried on MEM_SIZE
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // mcause codes reported on MEM_EXC_CAUSE
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  // Byte-enable pattern for an access of the given size at offset 0
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store shift/strobes, load extract/extend, alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [63:0] st_data,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        misaligned,
  input  logic [2:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [63:0] rdata,
  output logic [63:0] ldata
);

  logic [63:0] rshift;

  // Store lanes and alignment for the access currently presented by MEM
  always_comb begin
    wdata = st_data << {st_off, 3'b000};
    wstrb = size_mask(st_size) << st_off;
    case (st_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = st_off[0];
      SZ_W:    misaligned = |st_off[1:0];
      default: misaligned = |st_off;
    endcase
  end

  // Load data: bring the addressed bytes down to bit 0, then extend
  always_comb begin
    rshift = rdata >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B:    ldata = ld_unsigned ? {56'd0, rshift[7:0]}  : {{56{rshift[7]}}, rshift[7:0]};
      SZ_H:    ldata = ld_unsigned ? {48'd0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
      SZ_W:    ldata = ld_unsigned ? {32'd0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
      default: ldata = rshift;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer over a request/acknowledge data-memory port.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            MEM_V,
  input  logic            MEM_LOAD,
  input  logic            MEM_STORE,
  input  logic [1:0]      MEM_SIZE,
  input  logic            MEM_UNSIGNED,
  input  logic [XLEN-1:0] MEM_ALU_RESULT,
  input  logic [XLEN-1:0] MEM_SR2,
  input  logic            WB_STALL,
  output logic            MEM_STALL,
  output logic [XLEN-1:0] MEM_RESULT,
  output logic            MEM_DONE,
  output logic            MEM_EXC,
  output logic [3:0]      MEM_EXC_CAUSE,
  output logic            DM_REQ,
  output logic            DM_WE,
  output logic [XLEN-1:0] DM_ADDR,
  output logic [XLEN-1:0] DM_WDATA,
  output logic [7:0]      DM_WSTRB,
  input  logic            DM_ACK,
  input  logic [XLEN-1:0] DM_RDATA,
  input  logic            DM_ERR
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            exc_q, exc_d;
  logic [3:0]      cause_q, cause_d;
  logic            capture;

  logic [XLEN-1:0] dm_addr_q, dm_wdata_q;
  logic            dm_we_q;
  logic [7:0]      dm_wstrb_q;
  logic [2:0]      ld_off_q;
  logic [1:0]      ld_size_q;
  logic            ld_uns_q;
  logic            is_load_q;

  logic            acc, is_load;
  logic [63:0]     lane_wdata, lane_ldata;
  logic [7:0]      lane_wstrb;
  logic            lane_mis;

  // Load wins when both load and store are flagged
  assign acc     = MEM_V & (MEM_LOAD | MEM_STORE);
  assign is_load = MEM_LOAD;

  mem_lane_align u_lane (
    .st_off      (MEM_ALU_RESULT[2:0]),
    .st_size     (MEM_SIZE),
    .st_data     (MEM_SR2),
    .wdata       (lane_wdata),
    .wstrb       (lane_wstrb),
    .misaligned  (lane_mis),
    .ld_off      (ld_off_q),
    .ld_size     (ld_size_q),
    .ld_unsigned (ld_uns_q),
    .rdata       (DM_RDATA),
    .ldata       (lane_ldata)
  );

  // Next-state, timeout counter and registered result/exception
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (lane_mis) begin
            exc_d    = 1'b1;
            cause_d  = is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
            result_d = '0;
            state_d  = DONE;
          end else begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An ack in the timeout cycle takes priority over the fault
        if (DM_ACK) begin
          state_d = DONE;
          if (DM_ERR) begin
            exc_d    = 1'b1;
            cause_d  = is_load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
            result_d = '0;
          end else begin
            result_d = is_load_q ? lane_ldata : '0;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d  = DONE;
          exc_d    = 1'b1;
          cause_d  = is_load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
          result_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!WB_STALL) begin
          state_d  = IDLE;
          result_d = '0;
          exc_d    = 1'b0;
          cause_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      cause_q  <= cause_d;
    end
  end

  // Bus request fields, captured once and held for the whole REQ phase
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_wstrb_q <= '0;
      ld_off_q   <= '0;
      ld_size_q  <= SZ_B;
      ld_uns_q   <= 1'b0;
      is_load_q  <= 1'b0;
    end else if (capture) begin
      dm_addr_q  <= {MEM_ALU_RESULT[XLEN-1:3], 3'b000};
      dm_wdata_q <= is_load ? '0 : lane_wdata;
      dm_we_q    <= ~is_load;
      dm_wstrb_q <= is_load ? 8'h00 : lane_wstrb;
      ld_off_q   <= MEM_ALU_RESULT[2:0];
      ld_size_q  <= MEM_SIZE;
      ld_uns_q   <= MEM_UNSIGNED;
      is_load_q  <= is_load;
    end
  end

  // Stall is gated by reset so it drops together with the abandoned request
  always_comb begin
    MEM_STALL     = RESET_N & (((state_q == IDLE) & acc) | (state_q == REQ));
    MEM_DONE      = (state_q == DONE);
    MEM_RESULT    = result_q;
    MEM_EXC       = exc_q;
    MEM_EXC_CAUSE = cause_q;
    DM_REQ        = (state_q == REQ);
    DM_WE         = dm_we_q;
    DM_ADDR       = dm_addr_q;
    DM_WDATA      = dm_wdata_q;
    DM_WSTRB      = dm_wstrb_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes expectations, monitor compares.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MEM_V, MEM_LOAD, MEM_STORE, MEM_UNSIGNED, WB_STALL;
  logic [1:0]  MEM_SIZE;
  logic [63:0] MEM_ALU_RESULT, MEM_SR2;
  logic        MEM_STALL, MEM_DONE, MEM_EXC;
  logic [63:0] MEM_RESULT;
  logic [3:0]  MEM_EXC_CAUSE;
  logic        DM_REQ, DM_WE, DM_ACK, DM_ERR;
  logic [63:0] DM_ADDR, DM_WDATA, DM_RDATA;
  logic [7:0]  DM_WSTRB;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] result;
    logic        exc;
    logic [3:0]  cause;
    int          stall;
    int          done_len;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } bus_t;

  exp_t eq[$];
  bus_t bq[$];

  mem_access_ctrl #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .MEM_V          (MEM_V),
    .MEM_LOAD       (MEM_LOAD),
    .MEM_STORE      (MEM_STORE),
    .MEM_SIZE       (MEM_SIZE),
    .MEM_UNSIGNED   (MEM_UNSIGNED),
    .MEM_ALU_RESULT (MEM_ALU_RESULT),
    .MEM_SR2        (MEM_SR2),
    .WB_STALL       (WB_STALL),
    .MEM_STALL      (MEM_STALL),
    .MEM_RESULT     (MEM_RESULT),
    .MEM_DONE       (MEM_DONE),
    .MEM_EXC        (MEM_EXC),
    .MEM_EXC_CAUSE  (MEM_EXC_CAUSE),
    .DM_REQ         (DM_REQ),
    .DM_WE          (DM_WE),
    .DM_ADDR        (DM_ADDR),
    .DM_WDATA       (DM_WDATA),
    .DM_WSTRB       (DM_WSTRB),
    .DM_ACK         (DM_ACK),
    .DM_RDATA       (DM_RDATA),
    .DM_ERR         (DM_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model plus memory responder for one MEM-stage access
  task automatic run_txn(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                         input logic [63:0] addr, input logic [63:0] sr2,
                         input logic [63:0] rdata, input int waits, input bit err,
                         input bit no_ack, input int wbs);
    exp_t        e;
    bus_t        b;
    int          nb, off, n;
    bit          mis, done;
    logic [63:0] mask, v;
    nb  = 1 << size;
    off = int'(addr % 8);
    mis = (addr % nb) != 0;
    e.done_len = wbs + 1;
    e.result   = '0;
    if (mis) begin
      e.exc   = 1'b1;
      e.cause = ld ? 4'd4 : 4'd6;
      e.stall = 1;
    end else begin
      b.addr  = addr - 64'(off);
      b.we    = !ld;
      b.wdata = ld ? 64'd0 : (sr2 << (8 * off));
      b.wstrb = ld ? 8'd0 : 8'(((1 << nb) - 1) << off);
      bq.push_back(b);
      if (no_ack) begin
        e.exc   = 1'b1;
        e.cause = ld ? 4'd5 : 4'd7;
        e.stall = 2 + TO;
      end else begin
        e.stall = 2 + waits;
        if (err) begin
          e.exc   = 1'b1;
          e.cause = ld ? 4'd5 : 4'd7;
        end else begin
          e.exc   = 1'b0;
          e.cause = 4'd0;
          if (ld) begin
            mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
            v    = (rdata >> (8 * off)) & mask;
            if (!uns && nb < 8 && v[8*nb-1]) v = v | ~mask;
            e.result = v;
          end
        end
      end
    end
    eq.push_back(e);

    @(posedge CLK); #1;
    MEM_V = 1'b1; MEM_LOAD = ld; MEM_STORE = st; MEM_SIZE = size; MEM_UNSIGNED = uns;
    MEM_ALU_RESULT = addr; MEM_SR2 = sr2; WB_STALL = 1'b0;
    n = 0; done = 1'b0;
    for (int g = 0; g < 40 && !done; g++) begin
      @(posedge CLK); #1;
      DM_ACK = 1'b0; DM_ERR = 1'b0; DM_RDATA = {$urandom, $urandom};
      if (MEM_DONE) done = 1'b1;
      else if (DM_REQ) begin
        if (!no_ack && n == waits) begin
          DM_ACK = 1'b1; DM_ERR = err; DM_RDATA = rdata;
        end
        n++;
      end
    end
    chk("txn_completes", 64'(done), 64'd1);
    MEM_V = 1'b0; MEM_LOAD = 1'b0; MEM_STORE = 1'b0;
    WB_STALL = (wbs > 0);
    repeat (wbs) @(posedge CLK);
    #1 WB_STALL = 1'b0;
  endtask

  // Monitor: compares bus fields during REQ and the result throughout DONE
  initial begin : monitor
    bit   prev_req, prev_done, have_cur, have_bus;
    int   stall_cnt, done_cnt;
    exp_t cur;
    bus_t cb;
    prev_req = 0; prev_done = 0; have_cur = 0; have_bus = 0; stall_cnt = 0; done_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        prev_req = 0; prev_done = 0; stall_cnt = 0; done_cnt = 0; have_bus = 0;
        continue;
      end
      if (DM_REQ) begin
        if (!prev_req) begin
          have_bus = bq.size() != 0;
          chk("bus_req_expected", 64'(have_bus), 64'd1);
          if (have_bus) cb = bq.pop_front();
        end
        if (have_bus) begin
          chk("dm_addr", DM_ADDR, cb.addr);
          chk("dm_we", 64'(DM_WE), 64'(cb.we));
          if (cb.we) begin
            chk("dm_wdata", DM_WDATA, cb.wdata);
            chk("dm_wstrb", 64'(DM_WSTRB), 64'(cb.wstrb));
          end
        end
      end
      if (MEM_STALL) stall_cnt++;
      if (MEM_DONE) begin
        if (!prev_done) begin
          have_cur = eq.size() != 0;
          chk("done_expected", 64'(have_cur), 64'd1);
          if (have_cur) begin
            cur = eq.pop_front();
            chk("stall_cycles", 64'(stall_cnt), 64'(cur.stall));
          end
          stall_cnt = 0;
          done_cnt  = 0;
        end
        done_cnt++;
        if (have_cur) begin
          chk("mem_result", MEM_RESULT, cur.result);
          chk("mem_exc", 64'(MEM_EXC), 64'(cur.exc));
          chk("mem_exc_cause", 64'(MEM_EXC_CAUSE), 64'(cur.cause));
        end
      end else if (prev_done) begin
        if (have_cur) chk("done_cycles", 64'(done_cnt), 64'(cur.done_len));
        chk("result_cleared", MEM_RESULT, 64'd0);
        chk("exc_cleared", {59'd0, MEM_EXC, MEM_EXC_CAUSE}, 64'd0);
      end
      prev_req  = DM_REQ;
      prev_done = MEM_DONE;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [1:0]  sz;
    logic [63:0] a;
    int          kind;
    RESET_N = 1'b0; MEM_V = 0; MEM_LOAD = 0; MEM_STORE = 0; MEM_SIZE = 0; MEM_UNSIGNED = 0;
    MEM_ALU_RESULT = 0; MEM_SR2 = 0; WB_STALL = 0; DM_ACK = 0; DM_RDATA = 0; DM_ERR = 0;
    #12;
    chk("rst_dm_req", 64'(DM_REQ), 64'd0);
    chk("rst_stall", 64'(MEM_STALL), 64'd0);
    chk("rst_done", 64'(MEM_DONE), 64'd0);
    chk("rst_result", MEM_RESULT, 64'd0);
    chk("rst_exc", {59'd0, MEM_EXC, MEM_EXC_CAUSE}, 64'd0);
    chk("rst_bus", DM_ADDR | DM_WDATA | {55'd0, DM_WE, DM_WSTRB}, 64'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;

    // SD with two wait states
    run_txn(0, 1, 2'd3, 0, 64'h1000, 64'h1122334455667788, 64'd0, 2, 0, 0, 0);
    // LB / LBU of byte 3 = 0x80
    run_txn(1, 0, 2'd0, 0, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0, 0, 0);
    run_txn(1, 0, 2'd0, 1, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0, 0, 0);
    // SH into the top lanes
    run_txn(0, 1, 2'd1, 0, 64'h2006, 64'h000000000000BEEF, 64'd0, 0, 0, 0, 0);
    // Misaligned LW, store timeout, load bus error, ack on the timeout cycle
    run_txn(1, 0, 2'd2, 0, 64'h1002, 64'd0, 64'd0, 0, 0, 0, 0);
    run_txn(0, 1, 2'd3, 0, 64'h3000, 64'hA5A5, 64'd0, 0, 0, 1, 0);
    run_txn(1, 0, 2'd3, 0, 64'h3008, 64'd0, 64'h1234, 1, 1, 0, 0);
    run_txn(1, 0, 2'd2, 0, 64'h3004, 64'd0, 64'hF000000100000000, TO, 0, 0, 0);
    // Result held while writeback stalls
    run_txn(1, 0, 2'd1, 0, 64'h4002, 64'd0, 64'h00000000ABCD0000, 1, 0, 0, 3);

    // Non-memory instruction passes through; stray ack outside REQ is ignored
    @(posedge CLK); #1;
    MEM_V = 1'b1; DM_ACK = 1'b1; DM_RDATA = '1;
    #1 chk("passthru_stall", 64'(MEM_STALL), 64'd0);
    @(posedge CLK); #1;
    chk("passthru_no_req", 64'(DM_REQ), 64'd0);
    chk("passthru_no_done", 64'(MEM_DONE), 64'd0);
    MEM_V = 1'b0; DM_ACK = 1'b0;

    // Reset while a request is outstanding
    @(posedge CLK); #1;
    MEM_V = 1'b1; MEM_STORE = 1'b1; MEM_SIZE = 2'd3; MEM_ALU_RESULT = 64'h5000;
    MEM_SR2 = 64'h77;
    @(posedge CLK); #1;
    chk("rst_pre_req", 64'(DM_REQ), 64'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_mid_req", 64'(DM_REQ), 64'd0);
    chk("rst_mid_stall", 64'(MEM_STALL), 64'd0);
    @(posedge CLK); #1;
    MEM_V = 1'b0; MEM_STORE = 1'b0; RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_req", 64'(DM_REQ), 64'd0);
    chk("post_rst_done", 64'(MEM_DONE), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      sz   = 2'($urandom_range(0, 3));
      a    = {48'd0, 4'($urandom_range(1, 15)), 9'($urandom), 3'($urandom)};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, kind != 0, sz, 1'($urandom), a, {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, TO), $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2));
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("exp_queue_drained", 64'(eq.size()), 64'd0);
    chk("bus_queue_drained", 64'(bq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage data-access controller for the RV64 core. It sits between the MEM pipeline stage and the data-memory port and sequences each load or store over a variable-latency request/acknowledge handshake. It handles byte-lane alignment, store strobes, load sign/zero extension, misalignment and access-fault detection, and a bus timeout. It stalls the MEM stage until the access result is ready for writeback.

## Interface
- `XLEN`, 64, data/address width; must be 64.
- `TIMEOUT_CYC`, 64, REQ-state cycles without `DM_ACK` before an access fault; range 1..255.

Ports:
- `CLK`  in  1  core clock; all state changes on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `MEM_V`  in  1  valid instruction in MEM.
- `MEM_LOAD`  in  1  instruction is a load.
- `MEM_STORE`  in  1  instruction is a store.
- `MEM_SIZE`  in  2  access size: 00=B, 01=H, 10=W, 11=D.
- `MEM_UNSIGNED`  in  1  zero-extend the load (LBU/LHU/LWU).
- `MEM_ALU_RESULT`  in  64  effective address.
- `MEM_SR2`  in  64  store data, right-justified.
- `WB_STALL`  in  1  writeback is stalled.
- `MEM_STALL`  out  1  hold the MEM stage.
- `MEM_RESULT`  out  64  extended load data; 0 for stores.
- `MEM_DONE`  out  1  access completed; result and exception are valid.
- `MEM_EXC`  out  1  access raised an exception.
- `MEM_EXC_CAUSE`  out  4  mcause code: 4=load misaligned, 5=load fault, 6=store misaligned, 7=store fault.
- `DM_REQ`  out  1  memory request.
- `DM_WE`  out  1  request is a write.
- `DM_ADDR`  out  64  doubleword-aligned address (`ADDR[2:0]`=0).
- `DM_WDATA`  out  64  lane-shifted store data.
- `DM_WSTRB`  out  8  byte write strobes.
- `DM_ACK`  in  1  request accepted and completed.
- `DM_RDATA`  in  64  read data; valid when `DM_ACK`=1.
- `DM_ERR`  in  1  bus error; qualified by `DM_ACK`.

## Operation
- Access condition: `acc` = `MEM_V` & (`MEM_LOAD` | `MEM_STORE`). If both `MEM_LOAD` and `MEM_STORE` are set, the access is treated as a load.
- When `MEM_V` is set but `acc` is 0, the controller passes the instruction through: no stall and no `MEM_DONE`.
- Misaligned means the address is not a multiple of 2^`MEM_SIZE`.
- FSM states: IDLE, REQ, DONE.
- IDLE, `acc` and misaligned:
  - go to DONE with `MEM_EXC`=1 and cause 4 (load) or 6 (store);
  - no bus request is issued.
- IDLE, `acc` and aligned:
  - register `DM_ADDR`, `DM_WE`, `DM_WDATA` and `DM_WSTRB`;
  - clear the timeout counter;
  - go to REQ.
- REQ:
  - `DM_REQ`=1 and all `DM_*` outputs are held stable until `DM_ACK`.
  - On `DM_ACK` with `DM_ERR`=0: capture the extended load into `MEM_RESULT` and go to DONE.
  - On `DM_ACK` with `DM_ERR`=1: exception with cause 5 or 7; go to DONE.
  - When the counter reaches `TIMEOUT_CYC` with no ack: drop `DM_REQ`, raise cause 5 or 7, go to DONE.
- DONE:
  - `MEM_DONE`=1.
  - If `WB_STALL`=1, stay in DONE with the result held.
  - Otherwise go to IDLE; the pipeline advances on that edge.
- `MEM_STALL` = (IDLE & `acc`) | REQ. It is combinational from state and inputs.
- Lane rules, with off = `ADDR[2:0]`:
  - `DM_WDATA` = `MEM_SR2` << 8·off.
  - `DM_WSTRB` = (2^(2^`MEM_SIZE`) − 1) << off.
  - Load: `DM_RDATA` >> 8·off, truncated to the access size, then sign- or zero-extended per `MEM_UNSIGNED`. For size D, `MEM_UNSIGNED` is ignored.
- For stores, `MEM_RESULT` is 0.

## Timing
- Reset (asynchronous, `RESET_N`=0): state=IDLE, counter=0, and all outputs are 0, including `DM_REQ`. A reset during REQ abandons the transaction immediately.
- Aligned access with ack in the first REQ cycle:
  - cycle 0: IDLE, stall;
  - cycle 1: REQ, stall;
  - cycle 2: DONE, no stall.
  - Minimum occupancy is 3 cycles.
- Misaligned access: cycle 0 IDLE with stall, cycle 1 DONE with the exception.
- Each additional wait cycle from memory adds one cycle in REQ.
- Timeout: fault reported `TIMEOUT_CYC`+1 cycles after entering REQ. A `DM_ACK` arriving in the same cycle as the timeout wins.
- `DM_ACK` is ignored outside REQ.
- `MEM_RESULT`, `MEM_EXC` and `MEM_EXC_CAUSE` are registered. They hold their values while in DONE and clear on the transition to IDLE.

## Structure
- Package `mem_pkg` holds:
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`;
  - the state enum `IDLE`/`REQ`/`DONE`;
  - cause constants `CAUSE_LD_MISALIGN`=4, `CAUSE_LD_FAULT`=5, `CAUSE_ST_MISALIGN`=6, `CAUSE_ST_FAULT`=7.
- Sub-module `mem_lane_align` is purely combinational and contains:
  - the store shift and strobe generation;
  - load extract and extend;
  - the misalignment check.

## Test plan
- SD store to 0x1000, data 0x1122334455667788, ack after 2 wait cycles: `DM_WSTRB`=0xFF and `DM_WDATA` equals the store data; `MEM_STALL` lasts 4 cycles; `MEM_DONE` for 1 cycle.
- LB from 0x1003 with `DM_RDATA`=0x00000000_80000000 (byte 3 = 0x80), immediate ack: `MEM_RESULT`=0xFFFFFFFFFFFFFF80. Repeating with LBU gives `MEM_RESULT`=0x80.
- SH to 0x2006, data 0xBEEF: `DM_WSTRB`=0xC0 and `DM_WDATA`=0xBEEF000000000000.
- LW from 0x1002: no `DM_REQ`; `MEM_EXC`=1 with cause 4 one cycle later.
- Store with no ack and `TIMEOUT_CYC`=4: `DM_REQ` drops after 5 REQ cycles; `MEM_EXC` with cause 7.
- Assert `RESET_N` low while in REQ: `DM_REQ` and `MEM_STALL` go to 0 immediately. With `WB_STALL`=1 held for 3 cycles in DONE, `MEM_RESULT` is stable throughout.
